fp_align_adder: RTL and testbench

Front half of the floating-point adder datapath. It accepts two IEEE-754 single-precision operands and unpacks them. It then aligns the smaller-magnitude operand to the larger exponent with a one-bit-per-cycle right shifter, and adds or subtracts the 24-bit significands. It emits the raw 24-bit sum, carry-out, result sign and pre-normalisation exponent, which feed directly into mantissa_normalizer (sum -> in, carry -> in_carry) and the downstream exponent-adjust/pack stage.

---
 rtl/fp_align_adder.sv | 132 +++++++++++++
 tb/tb_fp_align_adder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fp_align_adder.sv
// Front half of the single-precision FP adder: unpack, swap, align the smaller
// significand one bit per cycle, then add/subtract the 24-bit significands.
module fp_align_adder #(
  parameter int MAX_SHIFT = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] sum_mant,
  output logic        sum_carry,
  output logic        result_sign,
  output logic [7:0]  result_exp,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int CNT_W = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, ADD, DONE} state_t;

  state_t state, state_nxt;

  logic             sign_l_p0, sign_s_p0;
  logic [7:0]       exp_l_p0;
  logic [23:0]      sig_l_p0, sig_s_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic [7:0]  exp_a, exp_b;
  logic [23:0] sig_a, sig_b;
  logic        a_is_l;
  logic [24:0] add_res;

  // Exponent differences at or beyond MAX_SHIFT would shift the whole
  // significand out, so the counter saturates there.
  function automatic logic [CNT_W-1:0] sat_shift(input logic [7:0] diff);
    if (32'(diff) >= MAX_SHIFT) return CNT_W'(MAX_SHIFT);
    else                        return CNT_W'(diff);
  endfunction

  // Effective subtraction never goes negative because L >= S by construction.
  function automatic logic [24:0] sig_addsub(input logic [23:0] sig_l,
                                             input logic [23:0] sig_s,
                                             input logic        sub);
    if (sub) return {1'b0, sig_l - sig_s};
    else     return {1'b0, sig_l} + {1'b0, sig_s};
  endfunction

  // Stage p0 input: unpack with zero/denormal flush-to-zero
  always_comb begin
    exp_a  = a[30:23];
    exp_b  = b[30:23];
    sig_a  = (exp_a != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
    sig_b  = (exp_b != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
    a_is_l = ({exp_a, sig_a} >= {exp_b, sig_b});
    add_res = sig_addsub(sig_l_p0, sig_s_p0, sign_l_p0 != sign_s_p0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)       state_nxt = ALIGN;
      ALIGN:   if (cnt_p0 == '0)   state_nxt = ADD;
      ADD:                         state_nxt = DONE;
      DONE:    if (out_ready)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_l_p0   <= 1'b0;
      sign_s_p0   <= 1'b0;
      exp_l_p0    <= 8'd0;
      sig_l_p0    <= 24'd0;
      sig_s_p0    <= 24'd0;
      cnt_p0      <= '0;
      sum_mant    <= 24'd0;
      sum_carry   <= 1'b0;
      result_sign <= 1'b0;
      result_exp  <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (a_is_l) begin
              sign_l_p0 <= a[31];
              sign_s_p0 <= b[31];
              exp_l_p0  <= exp_a;
              sig_l_p0  <= sig_a;
              sig_s_p0  <= sig_b;
              cnt_p0    <= sat_shift(exp_a - exp_b);
            end else begin
              sign_l_p0 <= b[31];
              sign_s_p0 <= a[31];
              exp_l_p0  <= exp_b;
              sig_l_p0  <= sig_b;
              sig_s_p0  <= sig_a;
              cnt_p0    <= sat_shift(exp_b - exp_a);
            end
          end
        end
        // Stage p1: truncating one-bit-per-cycle alignment shift
        ALIGN: begin
          if (cnt_p0 != '0) begin
            sig_s_p0 <= sig_s_p0 >> 1;
            cnt_p0   <= cnt_p0 - 1'b1;
          end
        end
        // Stage p2: significand add/sub into the held output registers
        ADD: begin
          sum_mant    <= add_res[23:0];
          sum_carry   <= add_res[24];
          result_exp  <= exp_l_p0;
          result_sign <= (sign_l_p0 != sign_s_p0 && add_res == 25'd0) ? 1'b0 : sign_l_p0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_adder.sv
// Directed-vector bench for fp_align_adder with hand-computed expectations.
module tb_fp_align_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        in_valid, in_ready;
  logic [23:0] sum_mant;
  logic        sum_carry, result_sign;
  logic [7:0]  result_exp;
  logic        out_valid, out_ready;

  int vecs = 0;
  int errs = 0;

  fp_align_adder #(.MAX_SHIFT(24)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid), .in_ready(in_ready),
    .sum_mant(sum_mant), .sum_carry(sum_carry), .result_sign(result_sign),
    .result_exp(result_exp), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Presents one operand pair for exactly one accept edge; returns just after it.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv);
    a = av; b = bv; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid is seen; bounded.
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    vecs++; if (sum_mant !== 24'h0) begin errs++; $display("FAIL reset_sum_mant got %h want 000000", sum_mant); end
    vecs++; if ({sum_carry, result_sign, result_exp} !== 10'h0) begin errs++; $display("FAIL reset_misc got %b want 0", {sum_carry, result_sign, result_exp}); end
    rst = 1'b0;
    @(posedge clk); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
  endtask

  task automatic test_equal_exp();
    int lat;
    start_op(32'h3F800000, 32'h3F800000);
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL one_busy got %0b want 0", in_ready); end
    wait_valid(lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL one_latency got %0d want 2", lat); end
    vecs++; if (sum_mant !== 24'h000000 || sum_carry !== 1'b1) begin errs++; $display("FAIL one_sum got %b_%h want 1_000000", sum_carry, sum_mant); end
    vecs++; if (result_exp !== 8'h7F || result_sign !== 1'b0) begin errs++; $display("FAIL one_exp_sign got %h/%0b want 7f/0", result_exp, result_sign); end
    release_out();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL one_release got v%0b r%0b want v0 r1", out_valid, in_ready); end
  endtask

  task automatic test_align();
    int lat;
    start_op(32'h3FC00000, 32'h3E800000);
    wait_valid(lat);
    vecs++; if (lat !== 4) begin errs++; $display("FAIL align_latency got %0d want 4", lat); end
    vecs++; if (sum_mant !== 24'hE00000 || sum_carry !== 1'b0) begin errs++; $display("FAIL align_sum got %b_%h want 0_e00000", sum_carry, sum_mant); end
    vecs++; if (result_exp !== 8'h7F || result_sign !== 1'b0) begin errs++; $display("FAIL align_exp_sign got %h/%0b want 7f/0", result_exp, result_sign); end
    release_out();
  endtask

  task automatic test_swap_sub();
    int lat;
    start_op(32'h3E800000, 32'hBFC00000);
    wait_valid(lat);
    vecs++; if (lat !== 4) begin errs++; $display("FAIL swap_latency got %0d want 4", lat); end
    vecs++; if (sum_mant !== 24'hA00000 || sum_carry !== 1'b0) begin errs++; $display("FAIL swap_sum got %b_%h want 0_a00000", sum_carry, sum_mant); end
    vecs++; if (result_exp !== 8'h7F || result_sign !== 1'b1) begin errs++; $display("FAIL swap_exp_sign got %h/%0b want 7f/1", result_exp, result_sign); end
    release_out();
  endtask

  task automatic test_cancel();
    int lat;
    start_op(32'h40400000, 32'hC0400000);
    wait_valid(lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL cancel_latency got %0d want 2", lat); end
    vecs++; if (sum_mant !== 24'h0 || sum_carry !== 1'b0) begin errs++; $display("FAIL cancel_sum got %b_%h want 0_000000", sum_carry, sum_mant); end
    vecs++; if (result_exp !== 8'h80 || result_sign !== 1'b0) begin errs++; $display("FAIL cancel_exp_sign got %h/%0b want 80/0", result_exp, result_sign); end
    release_out();
  endtask

  task automatic test_saturation_backpressure();
    int lat;
    start_op(32'h4B800000, 32'h3F800000);
    wait_valid(lat);
    vecs++; if (lat !== 26) begin errs++; $display("FAIL sat_latency got %0d want 26", lat); end
    vecs++; if (sum_mant !== 24'h800000 || sum_carry !== 1'b0) begin errs++; $display("FAIL sat_sum got %b_%h want 0_800000", sum_carry, sum_mant); end
    vecs++; if (result_exp !== 8'h97 || result_sign !== 1'b0) begin errs++; $display("FAIL sat_exp_sign got %h/%0b want 97/0", result_exp, result_sign); end
    a = 32'h40400000; b = 32'h3F800000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum_mant !== 24'h800000 || result_exp !== 8'h97) begin
        errs++; $display("FAIL hold_%0d got v%0b r%0b %h/%h want v1 r0 800000/97", i, out_valid, in_ready, sum_mant, result_exp);
      end
    end
    in_valid = 1'b0;
    release_out();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL sat_release got v%0b r%0b want v0 r1", out_valid, in_ready); end
    vecs++; if (sum_mant !== 24'h800000) begin errs++; $display("FAIL sat_persist got %h want 800000", sum_mant); end
    @(posedge clk); #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL sat_idle_stays got %0b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_align();
    int lat;
    start_op(32'h44800000, 32'h3F800000);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    vecs++; if (sum_mant !== 24'h0 || result_exp !== 8'h0 || sum_carry !== 1'b0 || result_sign !== 1'b0) begin
      errs++; $display("FAIL midrst_outputs got %h/%h/%b/%b want 0", sum_mant, result_exp, sum_carry, result_sign);
    end
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL midrst_out_valid got %0b want 0", out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL midrst_in_ready got %0b want 1", in_ready); end
    @(posedge clk); #1;
    start_op(32'h3F800000, 32'h3F800000);
    wait_valid(lat);
    vecs++; if (lat !== 2) begin errs++; $display("FAIL post_rst_latency got %0d want 2", lat); end
    vecs++; if ({sum_carry, sum_mant} !== 25'h1000000 || result_exp !== 8'h7F) begin errs++; $display("FAIL post_rst_sum got %b_%h/%h want 1_000000/7f", sum_carry, sum_mant, result_exp); end
    release_out();
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(32'h3FC00000, 32'h3F800000);
    wait_valid(lat);
    vecs++; if (lat !== 2 || {sum_carry, sum_mant} !== 25'h1400000) begin errs++; $display("FAIL b2b_first got lat%0d %b_%h want lat2 1_400000", lat, sum_carry, sum_mant); end
    release_out();
    start_op(32'hBF800000, 32'h3F000000);
    wait_valid(lat);
    vecs++; if (lat !== 3) begin errs++; $display("FAIL b2b_latency got %0d want 3", lat); end
    vecs++; if (sum_mant !== 24'h400000 || sum_carry !== 1'b0 || result_sign !== 1'b1 || result_exp !== 8'h7F) begin
      errs++; $display("FAIL b2b_second got %b_%h s%0b e%h want 0_400000 s1 e7f", sum_carry, sum_mant, result_sign, result_exp);
    end
    release_out();
  endtask

  initial begin
    a = 32'h0; b = 32'h0; in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    test_reset();
    test_equal_exp();
    test_align();
    test_swap_sub();
    test_cancel();
    test_saturation_backpressure();
    test_reset_mid_align();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
